// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to the program RAM and
// buffers returned words with their PCs in a 2-entry queue for the decoder.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PRAM_AW  = 10
) (
   input  logic               clk,
   input  logic               rst,
   output logic               pram_en,
   output logic [PRAM_AW-1:0] pram_addr,
   input  logic [31:0]        pram_rdata,
   input  logic               redirect_en,
   input  logic [31:0]        redirect_pc,
   output logic [31:0]        inst_out,
   output logic [31:0]        pc_out,
   output logic               inst_valid,
   input  logic               id_ready
);

   localparam logic [31:0] NOP_INST     = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_ALN = RESET_PC & ~32'd3;

   // Fetch PC and in-flight read tracking
   logic [31:0] fpc_q, fpc_d;
   logic [31:0] ipc_q, ipc_d;
   logic        inflight_q, inflight_d;
   logic        kill_q, kill_d;

   // Queue control; head_q selects the oldest of the two slots
   logic [1:0]  count_q, count_d;
   logic        head_q, head_d;

   // Queue storage
   logic [31:0] inst_mem_q [2];
   logic [31:0] pc_mem_q   [2];

   logic        pop;
   logic        push;
   logic        inflight_live;
   logic [2:0]  occupancy;
   logic        tail;
   logic        unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Head output; an empty queue presents a NOP at PC 0
   assign inst_valid = (count_q != 2'd0);
   assign inst_out   = inst_valid ? inst_mem_q[head_q] : NOP_INST;
   assign pc_out     = inst_valid ? pc_mem_q[head_q]   : 32'h0000_0000;

   assign pram_addr  = fpc_q[PRAM_AW+1:2];

   always_comb begin
      inflight_live = inflight_q & ~kill_q;
      pop           = inst_valid & id_ready & ~redirect_en;
      // Entries left after this cycle's pop plus the read that lands this cycle; the
      // pop can never exceed count, so the subtraction cannot underflow.
      occupancy     = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_live};
      pram_en       = ~rst & ~redirect_en & (occupancy <= 3'd1);
      // A push with count == 2 cannot happen, so the tail is head offset by count[0].
      tail          = head_q ^ count_q[0];
   end

   // NOTE: every signal written here gets a default first so no path leaves it unassigned,
   // which is what keeps this block from inferring latches.
   always_comb begin
      fpc_d      = fpc_q;
      ipc_d      = ipc_q;
      inflight_d = pram_en;
      kill_d     = 1'b0;
      count_d    = count_q;
      head_d     = head_q;
      push       = 1'b0;

      if (redirect_en) begin
         count_d = 2'd0;
         head_d  = 1'b0;
         kill_d  = inflight_q;
         fpc_d   = {redirect_pc[31:2], 2'b00};
      end else begin
         push    = inflight_live;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
         head_d  = head_q ^ pop;
         if (pram_en) begin
            ipc_d = fpc_q;
            fpc_d = fpc_q + 32'd4;
         end
      end
   end

   // NOTE: sequential state is written only with non-blocking assignments so every flop
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q      <= RESET_PC_ALN;
         ipc_q      <= 32'h0000_0000;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
         count_q    <= 2'd0;
         head_q     <= 1'b0;
      end else begin
         fpc_q      <= fpc_d;
         ipc_q      <= ipc_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
         count_q    <= count_d;
         head_q     <= head_d;
      end
   end

   // NOTE: queue storage is deliberately not reset; count_q gates every read of it, so
   // stale contents are never visible and the slots stay plain enable flops.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         inst_mem_q[tail] <= pram_rdata;
         pc_mem_q[tail]   <= ipc_q;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a PRAM model plus an in-order PC-stream scoreboard,
// directed timing scenarios and a randomized ready/redirect/reset run.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          AW     = 10;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst;
   logic          pram_en;
   logic [AW-1:0] pram_addr;
   logic [31:0]   pram_rdata;
   logic          redirect_en;
   logic [31:0]   redirect_pc;
   logic [31:0]   inst_out;
   logic [31:0]   pc_out;
   logic          inst_valid;
   logic          id_ready;

   int          checks  = 0;
   int          errors  = 0;
   int          accepts = 0;
   logic [31:0] exp_pc  = RST_PC;

   logic        hold_prev = 1'b0;
   logic [31:0] hold_pc, hold_inst;

   fetch_unit #(.RESET_PC(RST_PC), .PRAM_AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .pram_en    (pram_en),
      .pram_addr  (pram_addr),
      .pram_rdata (pram_rdata),
      .redirect_en(redirect_en),
      .redirect_pc(redirect_pc),
      .inst_out   (inst_out),
      .pc_out     (pc_out),
      .inst_valid (inst_valid),
      .id_ready   (id_ready)
   );

   always #5 clk = ~clk;

   // Program RAM: word k holds 0xA000_0000 + k; garbage whenever no read was issued.
   always @(posedge clk) begin
      if (pram_en === 1'b1) pram_rdata <= 32'hA000_0000 + {{(32-AW){1'b0}}, pram_addr};
      else                  pram_rdata <= $urandom;
   end

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return 32'hA000_0000 + ((pc >> 2) % (32'd1 << AW));
   endfunction

   // Scoreboard: accepted instructions must follow exp_pc in order with matching data,
   // a stalled head must not move, and an empty head must show NOP at PC 0.
   always @(negedge clk) begin
      if (rst === 1'b0 && hold_prev) begin
         checks++;
         if (inst_valid !== 1'b1 || pc_out !== hold_pc || inst_out !== hold_inst) begin
            errors++;
            $display("FAIL hold_stable: got v=%b pc=%h inst=%h, expected v=1 pc=%h inst=%h",
                     inst_valid, pc_out, inst_out, hold_pc, hold_inst);
         end
      end
      hold_prev = (rst === 1'b0) && (inst_valid === 1'b1) && !id_ready && !redirect_en;
      hold_pc   = pc_out;
      hold_inst = inst_out;

      if (inst_valid === 1'b0) begin
         checks++;
         if (inst_out !== NOP || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL idle_output: got inst=%h pc=%h, expected inst=%h pc=0", inst_out, pc_out, NOP);
         end
      end

      if (rst === 1'b0 && inst_valid === 1'b1 && id_ready && !redirect_en) begin
         checks++;
         if (pc_out !== exp_pc || inst_out !== word_at(exp_pc)) begin
            errors++;
            $display("FAIL accept_order: got pc=%h inst=%h, expected pc=%h inst=%h",
                     pc_out, inst_out, exp_pc, word_at(exp_pc));
         end
         exp_pc = exp_pc + 32'd4;
         accepts++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] want);
      // Thin wrapper kept local to the directed tasks below; each call is one comparison.
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic redirect_to(input logic [31:0] target, input logic ready);
      tick();
      redirect_en = 1'b1;
      redirect_pc = target;
      id_ready    = ready;
      exp_pc      = target & ~32'd3;
   endtask

   task automatic test_reset();
      rst = 1'b1; id_ready = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
      exp_pc = RST_PC;
      tick();
      @(negedge clk);
      expect_val("reset_pram_en",    {31'b0, pram_en},    32'd0);
      expect_val("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
      expect_val("reset_inst_out",   inst_out,            NOP);
      expect_val("reset_pc_out",     pc_out,              32'd0);
      expect_val("reset_pram_addr",  {22'b0, pram_addr},  {22'b0, RST_PC[AW+1:2]});
      tick();
      rst = 1'b0;
      @(negedge clk);
      expect_val("c0_pram_en",    {31'b0, pram_en},    32'd1);
      expect_val("c0_pram_addr",  {22'b0, pram_addr},  {22'b0, RST_PC[AW+1:2]});
      expect_val("c0_inst_valid", {31'b0, inst_valid}, 32'd0);
      tick();
      @(negedge clk);
      expect_val("c1_inst_valid", {31'b0, inst_valid}, 32'd0);
      tick();
      @(negedge clk);
      expect_val("c2_inst_valid", {31'b0, inst_valid}, 32'd1);
      expect_val("c2_pc_out",     pc_out,              RST_PC);
   endtask

   task automatic test_stream();
      for (int i = 0; i < 20; i++) begin
         tick();
         @(negedge clk);
         expect_val("stream_valid",   {31'b0, inst_valid}, 32'd1);
         expect_val("stream_pram_en", {31'b0, pram_en},    32'd1);
      end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      tick();
      id_ready = 1'b0;
      @(negedge clk);
      held = pc_out;
      for (int i = 1; i < 5; i++) begin
         tick();
         @(negedge clk);
         expect_val("stall_pram_en", {31'b0, pram_en}, 32'd0);
         expect_val("stall_head_pc", pc_out,           held);
      end
      tick();
      id_ready = 1'b1;
      @(negedge clk);
      expect_val("resume_pram_en", {31'b0, pram_en}, 32'd1);
      expect_val("resume_head_pc", pc_out,           held);
      for (int i = 0; i < 6; i++) begin
         tick();
         @(negedge clk);
         expect_val("resume_valid", {31'b0, inst_valid}, 32'd1);
      end
   endtask

   task automatic check_redirect(input string tag, input logic [31:0] target);
      logic [31:0] aligned;
      aligned = target & ~32'd3;
      @(negedge clk);
      expect_val({tag, "_t0_pram_en"}, {31'b0, pram_en}, 32'd0);
      tick();
      redirect_en = 1'b0;
      id_ready    = 1'b1;
      @(negedge clk);
      expect_val({tag, "_t1_valid"},     {31'b0, inst_valid}, 32'd0);
      expect_val({tag, "_t1_pram_addr"}, {22'b0, pram_addr},  {22'b0, aligned[AW+1:2]});
      tick();
      @(negedge clk);
      expect_val({tag, "_t2_valid"}, {31'b0, inst_valid}, 32'd0);
      tick();
      @(negedge clk);
      expect_val({tag, "_t3_pc"}, pc_out, aligned);
      tick();
      @(negedge clk);
      expect_val({tag, "_t4_pc"}, pc_out, aligned + 32'd4);
   endtask

   task automatic test_redirect_full();
      tick();
      id_ready = 1'b0;
      redirect_en = 1'b1;
      redirect_pc = 32'h0000_0203;
      exp_pc      = 32'h0000_0200;
      @(negedge clk);
      expect_val("redir_full_pre_valid", {31'b0, inst_valid}, 32'd1);
      check_redirect("redir_full", 32'h0000_0203);
   endtask

   task automatic test_redirect_pop();
      redirect_to(32'h0000_0340, 1'b1);
      @(negedge clk);
      expect_val("redir_pop_pre_valid", {31'b0, inst_valid}, 32'd1);
      check_redirect("redir_pop", 32'h0000_0340);
   endtask

   task automatic test_back_to_back();
      redirect_to(32'h0000_0500, 1'b1);
      redirect_to(32'h0000_0604, 1'b1);
      check_redirect("redir_b2b", 32'h0000_0604);
   endtask

   task automatic test_wrap();
      redirect_to(32'hFFFF_FFFC, 1'b1);
      @(negedge clk);
      tick();
      redirect_en = 1'b0;
      @(negedge clk);
      expect_val("wrap_addr_top", {22'b0, pram_addr}, 32'h0000_03FF);
      tick();
      @(negedge clk);
      expect_val("wrap_addr_zero", {22'b0, pram_addr}, 32'h0000_0000);
      tick();
      @(negedge clk);
      expect_val("wrap_pc_top",   pc_out,   32'hFFFF_FFFC);
      expect_val("wrap_inst_top", inst_out, 32'hA000_03FF);
      tick();
      @(negedge clk);
      expect_val("wrap_pc_zero",   pc_out,   32'h0000_0000);
      expect_val("wrap_inst_zero", inst_out, 32'hA000_0000);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) tick();
      rst    = 1'b1;
      exp_pc = RST_PC;
      @(negedge clk);
      expect_val("rmid_pram_en", {31'b0, pram_en}, 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      expect_val("rmid_valid",     {31'b0, inst_valid}, 32'd0);
      expect_val("rmid_inst",      inst_out,            NOP);
      expect_val("rmid_pram_addr", {22'b0, pram_addr},  {22'b0, RST_PC[AW+1:2]});
      tick();
      tick();
      @(negedge clk);
      expect_val("rmid_restart_pc", pc_out, RST_PC);
   endtask

   task automatic test_random();
      int start;
      int r;
      logic [31:0] target;
      start = accepts;
      for (int i = 0; i < 600; i++) begin
         tick();
         r           = int'($urandom_range(0, 99));
         rst         = (r < 2);
         redirect_en = (r >= 2 && r < 8);
         id_ready    = ($urandom_range(0, 3) != 0);
         target      = $urandom;
         redirect_pc = target;
         if (rst)              exp_pc = RST_PC;
         else if (redirect_en) exp_pc = target & ~32'd3;
      end
      tick();
      rst = 1'b0; redirect_en = 1'b0; id_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      @(negedge clk);
      checks++;
      if (accepts - start < 100) begin
         errors++;
         $display("FAIL random_progress: got %0d accepts, expected at least 100", accepts - start);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_full();
      test_redirect_pop();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
